// File: rtl/zap_wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encodings.
package zap_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_t;

    // Port index helpers used when naming the owner of the bus.
    localparam logic PORT_TLB  = 1'b0;
    localparam logic PORT_FILL = 1'b1;

    // Round-robin pick: the port that did not win last time.
    function automatic logic rr_pick(input logic last_gnt);
        return ~last_gnt;
    endfunction

endpackage

// File: rtl/zap_wb_arb_mux.sv
// 2:1 selector of the full next-cycle Wishbone bundle, steered by the
// port that will own the bus after the coming edge.
module zap_wb_arb_mux #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_pick,
    input  logic                i_cyc_0,
    input  logic                i_stb_0,
    input  logic [ADDR_W-1:0]   i_adr_0,
    input  logic                i_wen_0,
    input  logic [DATA_W/8-1:0] i_sel_0,
    input  logic [DATA_W-1:0]   i_dat_0,
    input  logic                i_cyc_1,
    input  logic                i_stb_1,
    input  logic [ADDR_W-1:0]   i_adr_1,
    input  logic                i_wen_1,
    input  logic [DATA_W/8-1:0] i_sel_1,
    input  logic [DATA_W-1:0]   i_dat_1,
    output logic                o_cyc,
    output logic                o_stb,
    output logic [ADDR_W-1:0]   o_adr,
    output logic                o_wen,
    output logic [DATA_W/8-1:0] o_sel,
    output logic [DATA_W-1:0]   o_dat
);

    // Whole-bundle select; no per-field steering.
    always_comb begin
        if (i_pick) begin
            o_cyc = i_cyc_1; o_stb = i_stb_1; o_adr = i_adr_1;
            o_wen = i_wen_1; o_sel = i_sel_1; o_dat = i_dat_1;
        end else begin
            o_cyc = i_cyc_0; o_stb = i_stb_0; o_adr = i_adr_0;
            o_wen = i_wen_0; o_sel = i_sel_0; o_dat = i_dat_0;
        end
    end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter (port 0: TLB walker, port 1: cache line fill).
// Acts as the output register stage for the owning master; a grant is held
// for the owner's whole cyc, and ownerships are separated by one idle cycle.
// Define ZAP_WB_ARB_RR_EN for round-robin on simultaneous requests;
// otherwise port 0 has fixed priority.
module zap_wb_arbiter
    import zap_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wb_cyc_nxt_0,
    input  logic                i_wb_stb_nxt_0,
    input  logic [ADDR_W-1:0]   i_wb_adr_nxt_0,
    input  logic                i_wb_wen_nxt_0,
    input  logic [DATA_W/8-1:0] i_wb_sel_nxt_0,
    input  logic [DATA_W-1:0]   i_wb_dat_nxt_0,
    input  logic                i_wb_cyc_nxt_1,
    input  logic                i_wb_stb_nxt_1,
    input  logic [ADDR_W-1:0]   i_wb_adr_nxt_1,
    input  logic                i_wb_wen_nxt_1,
    input  logic [DATA_W/8-1:0] i_wb_sel_nxt_1,
    input  logic [DATA_W-1:0]   i_wb_dat_nxt_1,
    output logic                o_gnt_0,
    output logic                o_gnt_1,
    output logic                o_wb_ack_0,
    output logic                o_wb_ack_1,
    output logic [DATA_W-1:0]   o_wb_rdat,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_wen,
    output logic [ADDR_W-1:0]   o_wb_adr,
    output logic [DATA_W/8-1:0] o_wb_sel,
    output logic [DATA_W-1:0]   o_wb_dat,
    input  logic                i_wb_ack,
    input  logic [DATA_W-1:0]   i_wb_dat
);

    arb_state_t state, state_nxt;
    logic       last_gnt;
    logic       owner_nxt;
    logic       grant_evt;
    logic       both_win;

    logic                m_cyc, m_stb, m_wen;
    logic [ADDR_W-1:0]   m_adr;
    logic [DATA_W/8-1:0] m_sel;
    logic [DATA_W-1:0]   m_dat;

`ifdef ZAP_WB_ARB_RR_EN
    assign both_win = rr_pick(last_gnt);
`else
    // Fixed priority: the walker always wins; last_gnt is tracked but inert.
    assign both_win = last_gnt & 1'b0;
`endif

    // Next-state and next-owner selection; IDLE is the only arbitration point.
    always_comb begin
        state_nxt = state;
        owner_nxt = PORT_TLB;
        grant_evt = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (i_wb_cyc_nxt_0 && i_wb_cyc_nxt_1) begin
                    owner_nxt = both_win;
                    state_nxt = both_win ? ARB_GNT1 : ARB_GNT0;
                    grant_evt = 1'b1;
                end else if (i_wb_cyc_nxt_0) begin
                    owner_nxt = PORT_TLB;
                    state_nxt = ARB_GNT0;
                    grant_evt = 1'b1;
                end else if (i_wb_cyc_nxt_1) begin
                    owner_nxt = PORT_FILL;
                    state_nxt = ARB_GNT1;
                    grant_evt = 1'b1;
                end
            end
            ARB_GNT0: begin
                owner_nxt = PORT_TLB;
                if (!i_wb_cyc_nxt_0) state_nxt = ARB_IDLE;
            end
            ARB_GNT1: begin
                owner_nxt = PORT_FILL;
                if (!i_wb_cyc_nxt_1) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    zap_wb_arb_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .i_pick  (owner_nxt),
        .i_cyc_0 (i_wb_cyc_nxt_0), .i_stb_0 (i_wb_stb_nxt_0),
        .i_adr_0 (i_wb_adr_nxt_0), .i_wen_0 (i_wb_wen_nxt_0),
        .i_sel_0 (i_wb_sel_nxt_0), .i_dat_0 (i_wb_dat_nxt_0),
        .i_cyc_1 (i_wb_cyc_nxt_1), .i_stb_1 (i_wb_stb_nxt_1),
        .i_adr_1 (i_wb_adr_nxt_1), .i_wen_1 (i_wb_wen_nxt_1),
        .i_sel_1 (i_wb_sel_nxt_1), .i_dat_1 (i_wb_dat_nxt_1),
        .o_cyc   (m_cyc), .o_stb (m_stb), .o_adr (m_adr),
        .o_wen   (m_wen), .o_sel (m_sel), .o_dat (m_dat)
    );

    // State register and last-winner tracking (last_gnt=1 so port 0 wins first).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ARB_IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant_evt) last_gnt <= owner_nxt;
        end
    end

    // Bus output registers: follow the owner every edge, clear when going idle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || state_nxt == ARB_IDLE) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_adr <= '0;
            o_wb_sel <= '0;
            o_wb_dat <= '0;
        end else begin
            o_wb_cyc <= m_cyc;
            o_wb_stb <= m_stb;
            o_wb_wen <= m_wen;
            o_wb_adr <= m_adr;
            o_wb_sel <= m_sel;
            o_wb_dat <= m_dat;
        end
    end

    assign o_gnt_0    = (state == ARB_GNT0);
    assign o_gnt_1    = (state == ARB_GNT1);
    assign o_wb_ack_0 = i_wb_ack & o_gnt_0 & o_wb_cyc;
    assign o_wb_ack_1 = i_wb_ack & o_gnt_1 & o_wb_cyc;
    assign o_wb_rdat  = i_wb_dat;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter; expectations cover both arbitration modes.
module tb_zap_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        cyc0 = 0, stb0 = 0, wen0 = 0, cyc1 = 0, stb1 = 0, wen1 = 0;
    logic [31:0] adr0 = 0, adr1 = 0, dat0 = 0, dat1 = 0;
    logic [3:0]  sel0 = 0, sel1 = 0;
    logic        gnt0, gnt1, ack0, ack1;
    logic [31:0] rdat, wb_adr, wb_dat;
    logic        wb_cyc, wb_stb, wb_wen;
    logic [3:0]  wb_sel;
    logic        wb_ack = 0;
    logic [31:0] wb_idat = 0;

    int checks = 0;
    int errors = 0;

    zap_wb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc_nxt_0(cyc0), .i_wb_stb_nxt_0(stb0), .i_wb_adr_nxt_0(adr0),
        .i_wb_wen_nxt_0(wen0), .i_wb_sel_nxt_0(sel0), .i_wb_dat_nxt_0(dat0),
        .i_wb_cyc_nxt_1(cyc1), .i_wb_stb_nxt_1(stb1), .i_wb_adr_nxt_1(adr1),
        .i_wb_wen_nxt_1(wen1), .i_wb_sel_nxt_1(sel1), .i_wb_dat_nxt_1(dat1),
        .o_gnt_0(gnt0), .o_gnt_1(gnt1), .o_wb_ack_0(ack0), .o_wb_ack_1(ack1),
        .o_wb_rdat(rdat), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen),
        .o_wb_adr(wb_adr), .o_wb_sel(wb_sel), .o_wb_dat(wb_dat),
        .i_wb_ack(wb_ack), .i_wb_dat(wb_idat)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ctl"}, {59'd0, wb_cyc, wb_stb, wb_wen, gnt0, gnt1}, 64'd0);
        chk({tag, "_bus"}, {wb_sel, wb_adr, 28'd0}, 64'd0);
        chk({tag, "_dat"}, {32'd0, wb_dat}, 64'd0);
    endtask

    task automatic pulse_reset();
        #1 i_reset = 1'b1;
        #1 i_reset = 1'b0;
    endtask

    logic [1:0] exp_order [4];

    initial begin
`ifdef ZAP_WB_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        // Reset state
        #2;
        all_zero("reset");
        tick();
        i_reset = 1'b0;

        // Single request on port 0
        cyc0 = 1; stb0 = 1; adr0 = 32'h0000_4000; wen0 = 0; sel0 = 4'hF;
        tick();
        chk("single_cyc", {62'd0, wb_cyc, wb_stb}, 64'd3);
        chk("single_adr", {32'd0, wb_adr}, 64'h4000);
        chk("single_gnt", {62'd0, gnt1, gnt0}, 64'd1);
        chk("single_noack", {62'd0, ack1, ack0}, 64'd0);
        tick();
        wb_ack = 1; wb_idat = 32'hDEAD_BEEF;
        #1;
        chk("single_ack", {62'd0, ack1, ack0}, 64'd1);
        chk("single_rdat", {32'd0, rdat}, 64'hDEAD_BEEF);
        cyc0 = 0; stb0 = 0;
        tick();
        wb_ack = 0;
        all_zero("single_rel");

        // Spurious ack while idle
        wb_ack = 1;
        #1;
        chk("spurious_ack", {62'd0, ack1, ack0}, 64'd0);
        wb_ack = 0;

        // Simultaneous requests right after reset
        pulse_reset();
        cyc0 = 1; stb0 = 1; adr0 = 32'h100; cyc1 = 1; stb1 = 1; adr1 = 32'h200;
        tick();
        chk("simul_gnt0", {62'd0, gnt1, gnt0}, 64'd1);
        chk("simul_adr0", {32'd0, wb_adr}, 64'h100);
        wb_ack = 1;
        #1;
        chk("simul_ack_owner", {62'd0, ack1, ack0}, 64'd1);
        cyc0 = 0; stb0 = 0;
        tick();
        wb_ack = 0;
        chk("simul_idle", {62'd0, wb_cyc, gnt1, gnt0}, 64'd0);
        tick();
        chk("simul_gnt1", {62'd0, gnt1, gnt0}, 64'd2);
        chk("simul_adr1", {32'd0, wb_adr}, 64'h200);
        cyc1 = 0; stb1 = 0;
        tick();
        chk("simul_rel", {63'd0, wb_cyc}, 64'd0);

        // Fairness: both request continuously, owner drops cyc for one edge
        cyc0 = 1; stb0 = 1; cyc1 = 1; stb1 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("order_%0d", i), {62'd0, gnt1, gnt0}, {62'd0, exp_order[i]});
            wb_ack = 1;
            if (gnt0) begin cyc0 = 0; stb0 = 0; end
            else      begin cyc1 = 0; stb1 = 0; end
            tick();
            wb_ack = 0;
            chk($sformatf("order_idle_%0d", i), {63'd0, wb_cyc}, 64'd0);
            cyc0 = 1; stb0 = 1; cyc1 = 1; stb1 = 1;
        end

        // Port 1 gets the bus once port 0 stops asking
        cyc0 = 0; stb0 = 0; adr1 = 32'h1000;
        tick();
        chk("fill_gnt1", {62'd0, gnt1, gnt0}, 64'd2);

        // Burst hold: 4-beat fill while port 0 waits; one beat has stb low
        cyc0 = 1; stb0 = 1;
        for (int b = 0; b < 4; b++) begin
            wb_ack = 1;
            #1;
            chk($sformatf("burst_ack_%0d", b), {62'd0, ack1, ack0}, 64'd2);
            adr1 = 32'h1000 + 32'(4 * (b + 1));
            stb1 = (b != 1);
            if (b == 3) begin cyc1 = 0; stb1 = 0; end
            tick();
            wb_ack = 0;
            if (b < 3) begin
                chk($sformatf("burst_hold_%0d", b), {62'd0, gnt1, gnt0}, 64'd2);
                chk($sformatf("burst_adr_%0d", b), {31'd0, wb_stb, wb_adr},
                    {31'd0, (b != 1), 32'h1000 + 32'(4 * (b + 1))});
            end
        end
        chk("burst_idle", {62'd0, wb_cyc, gnt0}, 64'd0);
        tick();
        chk("burst_then_gnt0", {62'd0, gnt1, gnt0}, 64'd1);
        chk("burst_then_adr", {32'd0, wb_adr}, 64'h100);

        // Reset during GNT1
        cyc0 = 0; stb0 = 0; cyc1 = 1; stb1 = 1; adr1 = 32'h300; wen1 = 1;
        tick();
        tick();
        chk("pre_rst_gnt1", {61'd0, wb_wen, gnt1, gnt0}, 64'd6);
        #2 i_reset = 1'b1;
        #1;
        all_zero("async_rst");
        wb_ack = 1;
        #1;
        chk("rst_no_ack", {62'd0, ack1, ack0}, 64'd0);
        wb_ack = 0;
        i_reset = 1'b0;
        cyc0 = 1; stb0 = 1; adr0 = 32'h500; wen1 = 0;
        tick();
        chk("post_rst_gnt0", {62'd0, gnt1, gnt0}, 64'd1);
        chk("post_rst_adr", {32'd0, wb_adr}, 64'h500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
